dec_ser_ctrl: RTL and testbench
===============================

DEC_SER_CTRL -- requirements
Module: dec_ser_ctrl

Interface
REQ-001 SHALL have parameter DW, default 11: data width of the driven shift register; only 11 is supported.
REQ-002 SHALL have parameter CW, default 15: codeword width; only 15 is supported.
REQ-003 SHALL have port clk  in  1: single clock; all controller state updates on the rising edge.
REQ-004 SHALL have port RST  in  1: reset, synchronous and active-high.
REQ-005 SHALL have port cw_valid  in  1: received codeword offered.
REQ-006 SHALL have port cw_ready  out  1: controller accepts a codeword.
REQ-007 SHALL have port cw_in  in  CW: received codeword; cw_in[i-1] holds Hamming position i (1..15).
REQ-008 SHALL have port sr_load  out  1: parallel-load strobe to the 11-bit negedge shift register.
REQ-009 SHALL have port sr_shift  out  1: shift-right strobe to the shift register.
REQ-010 SHALL have port sr_par_load  out  DW: corrected data word for the shift register load.
REQ-011 SHALL have port sr_sl_in  out  1: serial fill bit into the shift register MSB; constant 0.
REQ-012 SHALL have port sr_q  in  DW: shift register contents.
REQ-013 SHALL have port out_bit  out  1: serial data bit, equal to sr_q[0].
REQ-014 SHALL have port out_valid  out  1: out_bit is valid.
REQ-015 SHALL have port out_ready  in  1: downstream accepts out_bit.
REQ-016 SHALL have port out_last  out  1: current bit is the 11th bit of the word.
REQ-017 SHALL have port err_flag  out  1: nonzero syndrome on the last accepted codeword.
REQ-018 SHALL have port err_pos  out  4: syndrome of the last accepted codeword, 0 meaning no error.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD and SHIFT.
REQ-020 IDLE SHALL drive cw_ready=1; cw_valid=1 SHALL capture cw_in, register the syndrome into err_pos and err_flag, and move to LOAD.
REQ-021 Syndrome SHALL be the XOR of indices i (1..15) for which cw_in[i-1]=1.
REQ-022 Data mapping SHALL be data[0..10] = positions 3,5,6,7,9,10,11,12,13,14,15 in ascending order.
REQ-023 LOAD SHALL last exactly one cycle: sr_load=1, sr_par_load = corrected data; then move to SHIFT with bit counter 0.
REQ-024 SHIFT SHALL drive out_valid=1, out_bit=sr_q[0], and out_last=1 when counter=10.
REQ-025 sr_shift SHALL equal (state==SHIFT && out_ready), combinationally; each such cycle increments the counter.
REQ-026 The shift register updates on the negedge within the strobe cycle; rising-edge strobes SHALL give it a half-cycle setup margin.
REQ-027 A transfer with counter=10 SHALL return the FSM to IDLE; the next codeword can be accepted in the following cycle.
REQ-028 Latency: codeword accepted at edge N SHALL give sr_load=1 in cycle N+1 and first out_valid in cycle N+2.
REQ-029 With out_ready=0, the FSM SHALL hold state, counter and out_bit; sr_shift SHALL stay 0.
REQ-030 cw_ready SHALL be 0 outside IDLE; cw_valid SHALL be ignored there.
REQ-031 sr_load and sr_shift SHALL never be asserted in the same cycle.
REQ-032 Syndromes 1, 2, 4 and 8 (parity-bit errors) SHALL leave data unchanged and set err_flag=1.

Reset
REQ-033 RST=1 at a rising edge SHALL force IDLE, counter=0, err_flag=0, err_pos=0, at any state including mid-SHIFT.
REQ-034 While in reset, sr_load=0, sr_shift=0, out_valid=0, out_last=0 and cw_ready=0; after reset, cw_ready=1.
REQ-035 The shift register content after reset SHALL NOT affect the controller; out_valid=0 covers it.

Configuration
REQ-036 Macro HAMMING_SEC_CORRECT_EN defined: the bit at position err_pos SHALL be inverted before data extraction.
REQ-037 Macro undefined: data SHALL be extracted from the uncorrected codeword (detect-only); err_flag and err_pos behave unchanged.

Verification
REQ-038 Verify: cw_in=15'h0000 -> 11 out_bit of 0, out_last on the 11th, err_flag=0, err_pos=0.
REQ-039 Verify: cw_in=15'h0007 -> first bit 1 then 10 zeros; err_flag=0.
REQ-040 Verify: cw_in=15'h0017 with macro -> err_pos=5, err_flag=1, bits 1 then 10 zeros. Without macro -> bits 1,1 then 9 zeros.
REQ-041 Verify: out_ready low for 3 cycles mid-word -> out_bit and counter held, sr_shift=0, word completes intact.
REQ-042 Verify: RST asserted at counter=5 -> next cycle IDLE, cw_ready=1, out_valid=0, err_flag=0; the next codeword decodes correctly.
REQ-043 Verify: cw_valid held high during SHIFT -> not accepted until IDLE; back-to-back words have exactly one LOAD cycle between them.

Source files
------------

// File: rtl/dec_ser_ctrl.sv
// ---------------------------------------------------------------------------
// dec_ser_ctrl
//
// Purpose:
//   Accepts a 15-bit Hamming(15,11) codeword and computes its syndrome. It
//   then loads the 11 data bits into an external negedge-clocked shift
//   register and streams them out LSB first, one bit per accepted transfer,
//   under a valid/ready handshake.
//
// Build option:
//   HAMMING_SEC_CORRECT_EN - when defined, the codeword bit named by the
//   syndrome is inverted before the data bits are extracted (single-error
//   correction). When undefined, data comes from the raw codeword
//   (detect-only). err_flag and err_pos behave the same either way.
//
// Ports:
//   clk          in   rising-edge clock for all controller state
//   RST          in   synchronous active-high reset
//   cw_valid     in   a codeword is offered on cw_in
//   cw_ready     out  controller can take a codeword (IDLE only)
//   cw_in        in   codeword, cw_in[i-1] = Hamming position i
//   sr_load      out  parallel-load strobe to the shift register
//   sr_shift     out  shift-right strobe to the shift register
//   sr_par_load  out  data word presented for the parallel load
//   sr_sl_in     out  serial fill bit into the shift register MSB (0)
//   sr_q         in   shift register contents
//   out_bit      out  serial data bit (sr_q[0])
//   out_valid    out  out_bit is valid
//   out_ready    in   downstream takes out_bit this cycle
//   out_last     out  current bit is the final bit of the word
//   err_flag     out  last accepted codeword had a nonzero syndrome
//   err_pos      out  syndrome of the last accepted codeword (0 = clean)
// ---------------------------------------------------------------------------
module dec_ser_ctrl #(
  parameter int DW = 11,
  parameter int CW = 15
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          cw_valid,
  output logic          cw_ready,
  input  logic [CW-1:0] cw_in,
  output logic          sr_load,
  output logic          sr_shift,
  output logic [DW-1:0] sr_par_load,
  output logic          sr_sl_in,
  input  logic [DW-1:0] sr_q,
  output logic          out_bit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          err_flag,
  output logic [3:0]    err_pos
);

`ifdef HAMMING_SEC_CORRECT_EN
  localparam bit CORRECT_EN = 1'b1;
`else
  localparam bit CORRECT_EN = 1'b0;
`endif

  // Counter value while the final (11th) bit is on out_bit.
  localparam logic [3:0] LAST_IDX = 4'(DW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [3:0]    bit_cnt;
  logic [3:0]    bit_cnt_next;
  logic          capture;
  logic [3:0]    syndrome;
  logic [DW-1:0] data_next;
  logic [DW-1:0] data_reg;

  // Only sr_q[0] is observed; the rest of the register is the shifter's own
  // business and never steers the controller.
  logic sr_q_unused;
  assign sr_q_unused = ^sr_q[DW-1:1];

  // Hamming position (1..15) that carries data bit k. Data sits on every
  // position that is not a power of two.
  function automatic logic [3:0] data_pos(input logic [3:0] k);
    logic [3:0] p;
    case (k)
      4'd0:    p = 4'd3;
      4'd1:    p = 4'd5;
      4'd2:    p = 4'd6;
      4'd3:    p = 4'd7;
      4'd4:    p = 4'd9;
      4'd5:    p = 4'd10;
      4'd6:    p = 4'd11;
      4'd7:    p = 4'd12;
      4'd8:    p = 4'd13;
      4'd9:    p = 4'd14;
      4'd10:   p = 4'd15;
      default: p = 4'd3;
    endcase
    return p;
  endfunction

  // Syndrome is the XOR of the positions of all set bits; a clean codeword
  // gives 0, a single flipped bit gives that bit's position.
  always_comb begin
    syndrome = '0;
    for (int i = 1; i <= CW; i++) begin
      if (cw_in[i-1]) begin
        syndrome = syndrome ^ 4'(i);
      end
    end
  end

  // Data extraction straight from cw_in so it can be registered at accept
  // time. A syndrome that names a parity position matches no data position,
  // so parity-bit errors leave the data untouched.
  always_comb begin
    data_next = '0;
    for (int k = 0; k < DW; k++) begin
      data_next[k] = cw_in[data_pos(4'(k)) - 4'd1]
                   ^ (CORRECT_EN && (syndrome == data_pos(4'(k))));
    end
  end

  // State register and bit counter.
  always_ff @(posedge clk) begin
    if (RST) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
    end
  end

  // Decoded word and error status, captured when a codeword is accepted.
  always_ff @(posedge clk) begin
    if (RST) begin
      data_reg <= '0;
      err_pos  <= '0;
      err_flag <= 1'b0;
    end else if (capture) begin
      data_reg <= data_next;
      err_pos  <= syndrome;
      err_flag <= (syndrome != 4'd0);
    end
  end

  // Next state and strobes. The strobes are combinational on the rising-edge
  // state so the negedge shift register sees them half a cycle early. Reset
  // forces every handshake and strobe low in the same cycle.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    capture      = 1'b0;
    cw_ready     = 1'b0;
    sr_load      = 1'b0;
    sr_shift     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;

    case (state)
      IDLE: begin
        cw_ready = 1'b1;
        if (cw_valid) begin
          capture    = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        sr_load      = 1'b1;
        bit_cnt_next = '0;
        state_next   = SHIFT;
      end
      SHIFT: begin
        out_valid = 1'b1;
        out_last  = (bit_cnt == LAST_IDX);
        if (out_ready) begin
          sr_shift = 1'b1;
          if (bit_cnt == LAST_IDX) begin
            bit_cnt_next = '0;
            state_next   = IDLE;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end
      end
      default: begin
        state_next   = IDLE;
        bit_cnt_next = '0;
      end
    endcase

    if (RST) begin
      capture   = 1'b0;
      cw_ready  = 1'b0;
      sr_load   = 1'b0;
      sr_shift  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
    end
  end

  assign sr_par_load = data_reg;
  assign sr_sl_in    = 1'b0;
  assign out_bit     = sr_q[0];

endmodule

// File: tb/tb_dec_ser_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dec_ser_ctrl
//
// Self-checking bench for dec_ser_ctrl. It includes a negedge 11-bit shift
// register behind the controller. A queue-based model predicts every output
// on every cycle, and the reassembled serial words are compared to
// hand-computed literals. Honours HAMMING_SEC_CORRECT_EN like the design.
// ---------------------------------------------------------------------------
module tb_dec_ser_ctrl;

  localparam int DW = 11;
  localparam int CW = 15;

  logic          clk       = 1'b0;
  logic          RST       = 1'b1;
  logic          cw_valid  = 1'b0;
  logic [CW-1:0] cw_in     = '0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] sr_q      = 11'h7FF;
  logic          cw_ready;
  logic          sr_load;
  logic          sr_shift;
  logic [DW-1:0] sr_par_load;
  logic          sr_sl_in;
  logic          out_bit;
  logic          out_valid;
  logic          out_last;
  logic          err_flag;
  logic [3:0]    err_pos;

  int errors = 0;
  int checks = 0;

  dec_ser_ctrl #(.DW(DW), .CW(CW)) dut (
    .clk         (clk),
    .RST         (RST),
    .cw_valid    (cw_valid),
    .cw_ready    (cw_ready),
    .cw_in       (cw_in),
    .sr_load     (sr_load),
    .sr_shift    (sr_shift),
    .sr_par_load (sr_par_load),
    .sr_sl_in    (sr_sl_in),
    .sr_q        (sr_q),
    .out_bit     (out_bit),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .err_flag    (err_flag),
    .err_pos     (err_pos)
  );

  always #5 clk = ~clk;

  // The shift register the controller drives, clocked on the falling edge.
  always @(negedge clk) begin
    if (sr_load) begin
      sr_q <= sr_par_load;
    end else if (sr_shift) begin
      sr_q <= {sr_sl_in, sr_q[DW-1:1]};
    end
  end

  // ---------------- behavioural model ----------------
  bit            m_armed        = 1'b0;
  bit            m_load_pending = 1'b0;
  logic [DW-1:0] m_pending_data = '0;
  bit            m_bits[$];
  logic [3:0]    m_err_pos      = '0;
  bit            m_err_flag     = 1'b0;

  logic [DW-1:0] lit_words[$];
  logic [DW-1:0] got_word = '0;
  int            got_idx  = 0;

  function automatic logic [3:0] modelSyndrome(input logic [CW-1:0] cw);
    int s;
    s = 0;
    for (int i = 1; i <= CW; i++) begin
      if (cw[i-1]) s = s ^ i;
    end
    return 4'(s);
  endfunction

  function automatic logic [DW-1:0] modelData(input logic [CW-1:0] cw);
    logic [CW-1:0] w;
    logic [DW-1:0] d;
    int            n;
`ifdef HAMMING_SEC_CORRECT_EN
    int            s;
`endif
    w = cw;
    d = '0;
    n = 0;
`ifdef HAMMING_SEC_CORRECT_EN
    s = int'(modelSyndrome(cw));
    if (s != 0) w[s-1] = ~w[s-1];
`endif
    for (int p = 1; p <= CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[n] = w[p-1];
        n++;
      end
    end
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Model advances on each rising edge using the inputs of the ending cycle.
  task automatic modelUpdate();
    if (RST) begin
      m_armed        = 1'b1;
      m_load_pending = 1'b0;
      m_bits.delete();
      m_err_pos      = '0;
      m_err_flag     = 1'b0;
    end else if (m_armed) begin
      if (!m_load_pending && m_bits.size() == 0) begin
        if (cw_valid) begin
          m_err_pos      = modelSyndrome(cw_in);
          m_err_flag     = (m_err_pos != 4'd0);
          m_pending_data = modelData(cw_in);
          m_load_pending = 1'b1;
        end
      end else if (m_load_pending) begin
        m_load_pending = 1'b0;
        for (int k = 0; k < DW; k++) m_bits.push_back(m_pending_data[k]);
      end else if (out_ready) begin
        void'(m_bits.pop_front());
      end
    end
  endtask

  task automatic compareCycle();
    bit ready_e;
    bit load_e;
    bit valid_e;
    bit last_e;
    bit shift_e;
    ready_e = !RST && !m_load_pending && (m_bits.size() == 0);
    load_e  = !RST && m_load_pending;
    valid_e = !RST && (m_bits.size() != 0);
    last_e  = valid_e && (m_bits.size() == 1);
    shift_e = valid_e && out_ready;
    checkOutput("cw_ready",  32'(cw_ready),  32'(ready_e));
    checkOutput("sr_load",   32'(sr_load),   32'(load_e));
    checkOutput("sr_shift",  32'(sr_shift),  32'(shift_e));
    checkOutput("out_valid", 32'(out_valid), 32'(valid_e));
    checkOutput("out_last",  32'(out_last),  32'(last_e));
    checkOutput("err_flag",  32'(err_flag),  32'(m_err_flag));
    checkOutput("err_pos",   32'(err_pos),   32'(m_err_pos));
    checkOutput("sr_sl_in",  32'(sr_sl_in),  32'(0));
    if (load_e) checkOutput("sr_par_load", 32'(sr_par_load), 32'(m_pending_data));
    if (valid_e) checkOutput("out_bit", 32'(out_bit), 32'(m_bits[0]));
    if (RST) begin
      got_idx  = 0;
      got_word = '0;
    end else if (shift_e) begin
      got_word[got_idx] = out_bit;
      got_idx++;
      if (last_e) begin
        if (lit_words.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL word: got %0h, expected no word", got_word);
        end else begin
          checkOutput("word", 32'(got_word), 32'(lit_words.pop_front()));
        end
        got_idx  = 0;
        got_word = '0;
      end
    end
  endtask

  always begin
    @(posedge clk);
    modelUpdate();
    #2;
    if (m_armed) compareCycle();
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input bit rst, input bit valid,
                               input logic [CW-1:0] cw, input bit ready);
    @(posedge clk);
    #1;
    RST       = rst;
    cw_valid  = valid;
    cw_in     = cw;
    out_ready = ready;
  endtask

  task automatic sendWord(input logic [CW-1:0] cw, input logic [DW-1:0] lit,
                          input bit expect_done);
    bit accepted;
    accepted = 1'b0;
    if (expect_done) lit_words.push_back(lit);
    for (int t = 0; t < 40 && !accepted; t++) begin
      applyStimulus(1'b0, 1'b1, cw, 1'b1);
      #1;
      accepted = cw_ready;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got cw_ready=0, expected 1 within 40 cycles");
    end
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 60 && !idle; t++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      #1;
      idle = cw_ready;
    end
    if (!idle) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: got cw_ready=0, expected 1 within 60 cycles");
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected completion before t=100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hold_cycles;
    bit seen;
    logic [DW-1:0] lit17;
`ifdef HAMMING_SEC_CORRECT_EN
    lit17 = 11'h001;
`else
    lit17 = 11'h003;
`endif
    // Pin the model against hand-decoded codewords.
    checkOutput("model_syn_0017", 32'(modelSyndrome(15'h0017)), 32'd5);
    checkOutput("model_syn_7fff", 32'(modelSyndrome(15'h7FFF)), 32'd0);
    checkOutput("model_dat_0017", 32'(modelData(15'h0017)), 32'(lit17));
    checkOutput("model_dat_5555", 32'(modelData(15'h5555)), 32'h55B);

    // Reset and the first cycle out of it.
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    #1;
    checkOutput("reset_cw_ready", 32'(cw_ready), 32'd0);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    #1;
    checkOutput("post_reset_cw_ready", 32'(cw_ready), 32'd1);
    checkOutput("post_reset_err_pos", 32'(err_pos), 32'd0);

    // Plain words, including parity-only and data-position errors.
    sendWord(15'h0000, 11'h000, 1'b1); waitIdle();
    sendWord(15'h0007, 11'h001, 1'b1); waitIdle();
    sendWord(15'h0017, lit17,   1'b1); waitIdle();
    checkOutput("err_pos_0017", 32'(err_pos), 32'd5);
    sendWord(15'h7FFF, 11'h7FF, 1'b1); waitIdle();
    sendWord(15'h0080, 11'h000, 1'b1); waitIdle();
    checkOutput("err_pos_parity8", 32'(err_pos), 32'd8);

    // Downstream stall for three cycles mid-word.
    sendWord(15'h5555, 11'h55B, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0);
    waitIdle();

    // Reset with five bits already sent, then a fresh word.
    sendWord(15'h7FFE, 11'h7FF, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    #1;
    checkOutput("abort_cw_ready", 32'(cw_ready), 32'd1);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_err_flag", 32'(err_flag), 32'd0);
    sendWord(15'h0007, 11'h001, 1'b1); waitIdle();

    // cw_valid held high through a whole word: back-to-back acceptance.
    sendWord(15'h0017, lit17, 1'b1);
    lit_words.push_back(11'h000);
    hold_cycles = 0;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      applyStimulus(1'b0, 1'b1, 15'h0080, 1'b1);
      #1;
      hold_cycles++;
      seen = cw_ready;
    end
    checkOutput("b2b_gap_cycles", 32'(hold_cycles), 32'd13);
    waitIdle();

    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("words_left", 32'(lit_words.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
